// File: rtl/ur408_gpr_pkg.sv
// Shared constants and types for the GPR write-back path.
package ur408_gpr_pkg;

  localparam int unsigned NREG    = 8;
  localparam int unsigned DW      = 8;
  localparam int unsigned RW      = $clog2(NREG);
  localparam int unsigned AGE_MAX = 3;
  localparam int unsigned AW      = $clog2(AGE_MAX + 1);

  localparam logic [RW-1:0] R6 = RW'(6);
  localparam logic [RW-1:0] R7 = RW'(7);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_e;

  typedef enum logic [1:0] {
    GntNone,
    GntAlu,
    GntLd,
    GntDbg
  } grant_e;

  function automatic logic [NREG-1:0] reg_onehot(logic [RW-1:0] idx);
    return NREG'(1) << idx;
  endfunction

endpackage

// File: rtl/gpr_wb_sched_if.sv
// Request/response bundle between execute, LSU, decode, debug and the write-back scheduler.
interface gpr_wb_sched_if;
  import ur408_gpr_pkg::*;

  logic              alu_valid;
  logic [RW-1:0]     alu_rx;
  logic [DW-1:0]     alu_data;
  logic              alu_pair;
  logic [2*DW-1:0]   alu_pdata;
  logic              alu_ready;

  logic              ld_issue;
  logic [RW-1:0]     ld_issue_rx;
  logic              ld_valid;
  logic [RW-1:0]     ld_rx;
  logic [DW-1:0]     ld_data;
  logic              ld_ready;

  logic [RW-1:0]     dec_rs1;
  logic [RW-1:0]     dec_rs2;
  logic [RW-1:0]     dec_rd;
  logic              hazard;

  logic              dbg_halt_req;
  logic              dbg_valid;
  logic [RW-1:0]     dbg_rx;
  logic [DW-1:0]     dbg_data;
  logic              dbg_ready;
  logic              dbg_halted;

  logic              issue_en;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   register_write;
  logic [DW-1:0]     rd_data;
  logic [2*DW-1:0]   cr_data;
  logic              rd_r0_mux;
  logic              rd_r1_mux;

  modport master (
    output alu_valid, alu_rx, alu_data, alu_pair, alu_pdata,
    output ld_issue, ld_issue_rx, ld_valid, ld_rx, ld_data,
    output dec_rs1, dec_rs2, dec_rd,
    output dbg_halt_req, dbg_valid, dbg_rx, dbg_data,
    input  alu_ready, ld_ready, hazard, dbg_ready, dbg_halted, issue_en, busy,
    input  register_write, rd_data, cr_data, rd_r0_mux, rd_r1_mux
  );

  modport slave (
    input  alu_valid, alu_rx, alu_data, alu_pair, alu_pdata,
    input  ld_issue, ld_issue_rx, ld_valid, ld_rx, ld_data,
    input  dec_rs1, dec_rs2, dec_rd,
    input  dbg_halt_req, dbg_valid, dbg_rx, dbg_data,
    output alu_ready, ld_ready, hazard, dbg_ready, dbg_halted, issue_en, busy,
    output register_write, rd_data, cr_data, rd_r0_mux, rd_r1_mux
  );

endinterface

// File: rtl/gpr_scoreboard.sv
// Load-pending scoreboard: one busy bit per GPR plus the decode hazard lookup.
module gpr_scoreboard
  import ur408_gpr_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            set_en_i,
  input  logic [RW-1:0]   set_rx_i,
  input  logic            clr_en_i,
  input  logic [RW-1:0]   clr_rx_i,
  input  logic [RW-1:0]   rs1_i,
  input  logic [RW-1:0]   rs2_i,
  input  logic [RW-1:0]   rd_i,
  output logic [NREG-1:0] busy_o,
  output logic            hazard_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_mask, clr_mask;

  // Clear is applied before set so a new load to the same register stays pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en_i) set_mask = reg_onehot(set_rx_i);
    if (clr_en_i) clr_mask = reg_onehot(clr_rx_i);
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign hazard_o = busy_q[rs1_i] | busy_q[rs2_i] | busy_q[rd_i];

endmodule

// File: rtl/gpr_wb_sched.sv
// GPR write-port arbiter (ALU / load / debug) with debug halt-drain sequencing.
module gpr_wb_sched
  import ur408_gpr_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  gpr_wb_sched_if.slave  bus
);

  state_e          state_q, state_d;
  logic [AW-1:0]   age_q, age_d;
  grant_e          gnt;
  logic            ld_force;
  logic            alu_hits_busy;

  // A load that has been starved long enough takes the port from the ALU.
  assign ld_force = bus.ld_valid && (age_q == AW'(AGE_MAX));

  always_comb begin
    gnt = GntNone;
    unique case (state_q)
      RUN, DRAIN: begin
        if (bus.alu_valid && !ld_force) gnt = GntAlu;
        else if (bus.ld_valid)          gnt = GntLd;
      end
      HALTED: begin
        if (bus.dbg_valid) gnt = GntDbg;
      end
      default: gnt = GntNone;
    endcase
  end

  always_comb begin
    bus.alu_ready      = 1'b0;
    bus.ld_ready       = 1'b0;
    bus.dbg_ready      = 1'b0;
    bus.register_write = '0;
    bus.rd_data        = '0;
    bus.cr_data        = '0;
    bus.rd_r0_mux      = 1'b0;
    bus.rd_r1_mux      = 1'b0;
    unique case (gnt)
      GntAlu: begin
        bus.alu_ready = 1'b1;
        if (bus.alu_pair) begin
          bus.register_write = reg_onehot(R6) | reg_onehot(R7);
          bus.cr_data        = bus.alu_pdata;
          bus.rd_r0_mux      = 1'b1;
          bus.rd_r1_mux      = 1'b1;
        end else begin
          bus.register_write = reg_onehot(bus.alu_rx);
          bus.rd_data        = bus.alu_data;
        end
      end
      GntLd: begin
        bus.ld_ready       = 1'b1;
        bus.register_write = reg_onehot(bus.ld_rx);
        bus.rd_data        = bus.ld_data;
      end
      GntDbg: begin
        bus.dbg_ready      = 1'b1;
        bus.register_write = reg_onehot(bus.dbg_rx);
        bus.rd_data        = bus.dbg_data;
      end
      default: ;
    endcase
  end

  assign bus.issue_en   = (state_q == RUN);
  assign bus.dbg_halted = (state_q == HALTED);

  // Age tracks consecutive starved cycles of a pending load return.
  always_comb begin
    age_d = age_q;
    if (state_q == HALTED || !bus.ld_valid || gnt == GntLd) begin
      age_d = '0;
    end else if (age_q != AW'(AGE_MAX)) begin
      age_d = age_q + AW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (bus.dbg_halt_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.dbg_halt_req) begin
          state_d = RUN;
        end else if (bus.busy == '0 && !bus.alu_valid && !bus.ld_valid) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (!bus.dbg_halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end

  gpr_scoreboard u_scoreboard (
    .clk_i    (clk),
    .rst_ni   (rst),
    .set_en_i (bus.ld_issue && bus.issue_en),
    .set_rx_i (bus.ld_issue_rx),
    .clr_en_i (gnt == GntLd),
    .clr_rx_i (bus.ld_rx),
    .rs1_i    (bus.dec_rs1),
    .rs2_i    (bus.dec_rs2),
    .rd_i     (bus.dec_rd),
    .busy_o   (bus.busy),
    .hazard_o (bus.hazard)
  );

  // Decode must stall on hazard, so the ALU never writes a load-pending register.
  assign alu_hits_busy = bus.alu_pair ? (bus.busy[R6] | bus.busy[R7]) : bus.busy[bus.alu_rx];

  a_alu_no_busy_write: assert property (
    @(posedge clk) disable iff (!rst) !(gnt == GntAlu && alu_hits_busy)
  );

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Directed self-checking bench for the GPR write-back scheduler.
module tb_gpr_wb_sched;
  import ur408_gpr_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  gpr_wb_sched_if bus ();

  gpr_wb_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.alu_valid    = 1'b0;
    bus.alu_rx       = '0;
    bus.alu_data     = '0;
    bus.alu_pair     = 1'b0;
    bus.alu_pdata    = '0;
    bus.ld_issue     = 1'b0;
    bus.ld_issue_rx  = '0;
    bus.ld_valid     = 1'b0;
    bus.ld_rx        = '0;
    bus.ld_data      = '0;
    bus.dec_rs1      = '0;
    bus.dec_rs2      = '0;
    bus.dec_rd       = '0;
    bus.dbg_valid    = 1'b0;
    bus.dbg_rx       = '0;
    bus.dbg_data     = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.dbg_halt_req = 1'b0;
    idle();
    #3;
    check_eq("rst_busy", 32'(bus.busy), 32'h00);
    check_eq("rst_rw", 32'(bus.register_write), 32'h00);
    check_eq("rst_halted", 32'(bus.dbg_halted), 32'h0);
    check_eq("rst_alu_rdy", 32'(bus.alu_ready), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ALU and load collide for four cycles; the load wins once aged.
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_rx = 3'd1; bus.alu_data = 8'h11;
    bus.ld_valid  = 1'b1; bus.ld_rx  = 3'd2; bus.ld_data  = 8'h22;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c < 3) begin
        check_eq("col_alu_rdy", 32'(bus.alu_ready), 32'h1);
        check_eq("col_ld_rdy", 32'(bus.ld_ready), 32'h0);
        check_eq("col_rw_alu", 32'(bus.register_write), 32'h02);
      end else begin
        check_eq("age_alu_rdy", 32'(bus.alu_ready), 32'h0);
        check_eq("age_ld_rdy", 32'(bus.ld_ready), 32'h1);
        check_eq("age_rw_ld", 32'(bus.register_write), 32'h04);
        check_eq("age_rd_data", 32'(bus.rd_data), 32'h22);
      end
      @(negedge clk);
    end
    #1;
    check_eq("age_clr_alu", 32'(bus.alu_ready), 32'h1);
    @(negedge clk);
    idle();

    // Scoreboard set, hazard on each decode field, clear on load grant.
    bus.ld_issue = 1'b1; bus.ld_issue_rx = 3'd5;
    #1 check_eq("iss_busy_now", 32'(bus.busy), 32'h00);
    @(negedge clk);
    bus.ld_issue = 1'b0; bus.dec_rs1 = 3'd5;
    #1;
    check_eq("sb_busy", 32'(bus.busy), 32'h20);
    check_eq("hz_rs1", 32'(bus.hazard), 32'h1);
    @(negedge clk);
    bus.dec_rs1 = 3'd0; bus.dec_rd = 3'd5;
    #1 check_eq("hz_rd", 32'(bus.hazard), 32'h1);
    @(negedge clk);
    bus.dec_rd = 3'd0; bus.dec_rs2 = 3'd5;
    bus.ld_valid = 1'b1; bus.ld_rx = 3'd5; bus.ld_data = 8'hA5;
    #1;
    check_eq("ld5_rw", 32'(bus.register_write), 32'h20);
    check_eq("ld5_data", 32'(bus.rd_data), 32'hA5);
    check_eq("hz_rs2", 32'(bus.hazard), 32'h1);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    #1;
    check_eq("ld5_busy", 32'(bus.busy), 32'h00);
    check_eq("ld5_hz", 32'(bus.hazard), 32'h0);
    @(negedge clk);
    idle();

    // Pair write followed by a plain write.
    bus.alu_valid = 1'b1; bus.alu_pair = 1'b1; bus.alu_rx = 3'd2; bus.alu_pdata = 16'h1234;
    #1;
    check_eq("pair_rw", 32'(bus.register_write), 32'hC0);
    check_eq("pair_cr", 32'(bus.cr_data), 32'h1234);
    check_eq("pair_mux0", 32'(bus.rd_r0_mux), 32'h1);
    check_eq("pair_mux1", 32'(bus.rd_r1_mux), 32'h1);
    @(negedge clk);
    bus.alu_pair = 1'b0; bus.alu_rx = 3'd3; bus.alu_data = 8'h5A;
    #1;
    check_eq("sgl_rw", 32'(bus.register_write), 32'h08);
    check_eq("sgl_data", 32'(bus.rd_data), 32'h5A);
    check_eq("sgl_cr", 32'(bus.cr_data), 32'h0);
    check_eq("sgl_mux", 32'({bus.rd_r1_mux, bus.rd_r0_mux}), 32'h0);
    @(negedge clk);
    idle();

    // Same-cycle issue and grant on r4: set wins.
    bus.ld_issue = 1'b1; bus.ld_issue_rx = 3'd4;
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_rx = 3'd4; bus.ld_data = 8'h44;
    #1;
    check_eq("same_busy_pre", 32'(bus.busy), 32'h10);
    check_eq("same_ld_rdy", 32'(bus.ld_ready), 32'h1);
    @(negedge clk);
    idle();
    #1 check_eq("same_busy", 32'(bus.busy), 32'h10);
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_rx = 3'd4;
    @(negedge clk);
    idle();
    #1 check_eq("r4_clear", 32'(bus.busy), 32'h00);

    // Halt with one load pending: drain, then debug write.
    @(negedge clk);
    bus.ld_issue = 1'b1; bus.ld_issue_rx = 3'd0;
    @(negedge clk);
    bus.ld_issue = 1'b0; bus.dbg_halt_req = 1'b1;
    #1;
    check_eq("halt_busy", 32'(bus.busy), 32'h01);
    check_eq("halt_issue_now", 32'(bus.issue_en), 32'h1);
    @(negedge clk);
    bus.ld_issue = 1'b1; bus.ld_issue_rx = 3'd3;
    bus.dbg_valid = 1'b1; bus.dbg_rx = 3'd3; bus.dbg_data = 8'h7E;
    #1;
    check_eq("drain_issue", 32'(bus.issue_en), 32'h0);
    check_eq("drain_halted", 32'(bus.dbg_halted), 32'h0);
    check_eq("drain_dbg_rdy", 32'(bus.dbg_ready), 32'h0);
    @(negedge clk);
    bus.ld_issue = 1'b0;
    #1;
    check_eq("drain_no_iss", 32'(bus.busy), 32'h01);
    check_eq("drain_wait", 32'(bus.dbg_halted), 32'h0);
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_rx = 3'd0; bus.ld_data = 8'h0F;
    #1 check_eq("drain_ld_rw", 32'(bus.register_write), 32'h01);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    #1;
    check_eq("drain_busy0", 32'(bus.busy), 32'h00);
    check_eq("drain_last", 32'(bus.dbg_halted), 32'h0);
    @(negedge clk);
    #1;
    check_eq("halted", 32'(bus.dbg_halted), 32'h1);
    check_eq("dbg_rdy", 32'(bus.dbg_ready), 32'h1);
    check_eq("dbg_rw", 32'(bus.register_write), 32'h08);
    check_eq("dbg_data", 32'(bus.rd_data), 32'h7E);

    // Reset while halted.
    @(negedge clk);
    bus.dbg_valid = 1'b0;
    #2 rst = 1'b0; bus.dbg_halt_req = 1'b0;
    #1;
    check_eq("rsth_halted", 32'(bus.dbg_halted), 32'h0);
    check_eq("rsth_rw", 32'(bus.register_write), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    #1 check_eq("rsth_issue", 32'(bus.issue_en), 32'h1);

    // Reset while draining with a load pending; late return leaves busy clear.
    @(negedge clk);
    bus.ld_issue = 1'b1; bus.ld_issue_rx = 3'd2;
    @(negedge clk);
    bus.ld_issue = 1'b0; bus.dbg_halt_req = 1'b1;
    #1 check_eq("rstd_busy_pre", 32'(bus.busy), 32'h04);
    @(negedge clk);
    #1 check_eq("rstd_drain", 32'(bus.issue_en), 32'h0);
    #1 rst = 1'b0; bus.dbg_halt_req = 1'b0;
    #1 check_eq("rstd_busy", 32'(bus.busy), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_rx = 3'd2; bus.ld_data = 8'h99;
    #1;
    check_eq("late_ld_rdy", 32'(bus.ld_ready), 32'h1);
    check_eq("late_ld_rw", 32'(bus.register_write), 32'h04);
    @(negedge clk);
    idle();
    #1;
    check_eq("late_busy", 32'(bus.busy), 32'h00);
    check_eq("late_issue", 32'(bus.issue_en), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
